output_arbiter: RTL
===================

# output_arbiter

Output-port arbiter and single-slot output buffer for one direction of the mesh router. It collects the per-direction requests and data produced by the five input interfaces (L, R, U, D, PE). It selects one winner per cycle by round-robin, latches the winning flit, and pulses the winner's buffer-clear. It then presents the flit to the downstream link with a send/ready handshake. One instance sits on each output direction of the router.

## Interface
- DATA_WIDTH, 64, flit width in bits
- NUM_REQ, 5, number of requesting input interfaces; index 4=L, 3=R, 2=U, 1=D, 0=PE
- CNT_WIDTH, 16, width of the packet counter (see Configuration)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  request from each input interface for this output
- datai  input  NUM_REQ*DATA_WIDTH  flattened flit bus; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- grant  output  NUM_REQ  one-hot, combinational; drives sig_buffer_clear of the winning input interface
- so  output  1  send-out, high while the output buffer holds a valid flit
- ro  input  1  downstream ready; the flit is consumed on a cycle with so && ro
- datao  output  DATA_WIDTH  registered output flit
- pkt_cnt  output  CNT_WIDTH  forwarded-flit counter

## Operation
- Two-state FSM on the output buffer:
  - EMPTY: so=0.
  - FULL: so=1.
- Consume when `so && ro`.
- Load enable is `load = |req && (state==EMPTY || consume)`. Load is allowed in the same cycle as consume, which sustains 1 flit/cycle.
- Transitions:
  - EMPTY→FULL on load.
  - FULL→EMPTY on consume && !load.
  - FULL→FULL on !consume, or on consume && load.
- Round-robin pointer `ptr` (log2 NUM_REQ bits):
  - Winner is the first i with req[i]=1, searching ptr, ptr+1, … modulo NUM_REQ.
  - On load, ptr ← (winner+1) mod NUM_REQ.
  - With no load, ptr is unchanged.
- The pointer wraps after index NUM_REQ-1 to 0. For NUM_REQ=5 the wrap is 4→0 and does not pass through values 5–7.
- `grant[winner]=1` only in cycles where load=1; grant is 0 otherwise.
- On load, `datao ← datai[winner]` at the rising edge. datao holds its value while FULL and not consumed.
- Requests arriving while FULL && !ro are not granted and stay pending at their input interfaces; no flit is dropped.
- Reset (asynchronous, rst=0), including mid-transfer:
  - state=EMPTY, so=0, datao=0, ptr=0, pkt_cnt=0.
  - A flit held at reset is discarded.
  - grant is 0 while rst=0.

## Timing
- Arbitration and grant are combinational within the cycle that req is presented.
- The input buffer clears at the same edge at which datao loads.
- Latency: req high in cycle n with the buffer EMPTY gives so=1 and a valid datao from cycle n+1.
- Throughput: with ro held high and continuous requests, one flit per cycle; grant is asserted every cycle.
- Back-pressure: ro=0 holds so, datao and ptr stable, and grant stays 0.
- Simultaneous consume and load: so stays 1, datao updates at the edge, and pkt_cnt increments once.
- A single requester repeatedly wins; ptr still advances to winner+1 on each load.

## Configuration
- `OUT_ARB_PKT_CNT_EN` defined:
  - pkt_cnt increments by 1 at every consume.
  - Wraps modulo 2^CNT_WIDTH (0xFFFF→0x0000 for the default width).
  - Resets to 0.
- `OUT_ARB_PKT_CNT_EN` undefined:
  - No counter register is built.
  - pkt_cnt is tied to 0.

## Test plan
- Reset:
  - Stimulus: drive rst=0 with req=5'b11111 and ro=1.
  - Required: so=0, datao=0, grant=0, pkt_cnt=0.
  - Then release rst, which gives grant=5'b00001 in the first cycle.
- Round-robin fairness:
  - Stimulus: req=5'b11111 held, ro=1, datai slice i = 64'h10+i.
  - Required: grant sequence 00001, 00010, 00100, 01000, 10000, 00001.
  - Required: datao sequence 0x10, 0x11, 0x12, 0x13, 0x14, each appearing one cycle after its grant.
- Back-pressure:
  - Stimulus: load a flit 64'hDEAD, then hold ro=0 for 4 cycles with req=5'b00110.
  - Required: so=1, datao=64'hDEAD, grant=0 throughout.
  - Then ro=1, which gives consume plus load in the same cycle with grant=5'b00010.
- Pointer skip and wrap:
  - Stimulus: with ptr=4 and req=5'b00100.
  - Required: grant=5'b00100 and ptr→3.
  - Stimulus: then req=5'b00011.
  - Required: grant=5'b01000 is invalid. With ptr=3 and no req at bits 3–4 the search wraps, so the correct response is grant=5'b00001.
- Reset mid-operation:
  - Stimulus: FULL with datao=64'hBEEF, then pulse rst=0 asynchronously between edges.
  - Required: so and datao go to 0 immediately, without waiting for a clock edge.
  - Required: the next grant after release favours index 0.
- Counter (with `OUT_ARB_PKT_CNT_EN`):
  - Stimulus: preload via 65535 consumes, then 1 more consume.
  - Required: pkt_cnt=0xFFFF, then 0x0000.
  - Without the macro: pkt_cnt stays 0.

Source files
------------

// File: rtl/output_arbiter.sv
// Output-port arbiter: round-robin selection among NUM_REQ input interfaces into a one-flit
// output buffer with send/ready handshake. Define OUT_ARB_PKT_CNT_EN to build the flit counter.
module output_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REQ    = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] datai_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          so_o,
    input  logic                          ro_i,
    output logic [DATA_WIDTH-1:0]         datao_o,
    output logic [CNT_WIDTH-1:0]          pkt_cnt_o
);
    localparam int unsigned     PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PtrW-1:0]       winner, idx;
    logic                  found, consume, load;

    // Rotating-priority search; the index wraps at NUM_REQ-1, never visiting unused codes.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == LastIdx) ? '0 : idx + 1'b1;
        end
    end

    assign so_o    = (state_q == StFull);
    assign consume = so_o && ro_i;
    // Gating with rst_ni keeps grant low while reset is held.
    assign load    = found && rst_ni && ((state_q == StEmpty) || consume);

    always_comb begin
        grant_o = '0;
        if (load) grant_o[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        if (load) begin
            state_d = StFull;
            ptr_d   = (winner == LastIdx) ? '0 : winner + 1'b1;
            data_d  = datai_i[winner*DATA_WIDTH +: DATA_WIDTH];
        end else if (consume) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

    assign datao_o = data_q;

`ifdef OUT_ARB_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (consume) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pkt_cnt_o = cnt_q;
`else
    assign pkt_cnt_o = '0;
`endif

endmodule
